dram_bank_ctrl: RTL and testbench

- Parametrised successor to the team's single-cycle simple_dram storage model.
- Adds a valid/ready request port and a single-bank open-row buffer, so latency depends on row hit, row miss or row conflict.
- Issues periodic auto-refresh that blocks new requests while it runs.
- Sits between a requester (CPU/bus master model) and the DRAM array model; the array is held internally.

---
 rtl/dram_bank_if.sv | 25 ++
 rtl/dram_bank_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dram_bank_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_bank_if.sv
// Requester-side bus of the single-bank DRAM controller: valid/ready request,
// one-cycle read response pulse and the refresh indicator.
interface dram_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              refresh_busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, refresh_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, refresh_busy
  );
endinterface

// File: rtl/dram_bank_ctrl.sv
// Single-bank DRAM controller with an open-row buffer, periodic auto-refresh and an
// internal array. Optional hit/miss/conflict counters are built when DRAM_BANK_STATS_EN is defined.
module dram_bank_ctrl #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 6,
  parameter int COL_W          = 2,
  parameter int T_ACT          = 2,
  parameter int T_REF          = 4,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  dram_bank_if.slave  bus
`ifdef DRAM_BANK_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
  output logic [15:0] stat_conflicts
`endif
);
  localparam int ROW_W  = ADDR_W - COL_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int ACT_CW = $clog2(T_ACT + 1);
  localparam int REF_CW = $clog2(T_REF + 1);
  localparam int TMR_W  = $clog2(REFRESH_PERIOD);

  localparam logic [ACT_CW-1:0] ACT_LOAD = ACT_CW'(T_ACT - 1);
  localparam logic [REF_CW-1:0] REF_LOAD = REF_CW'(T_REF - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_ACTIVATE,
    ST_ACCESS,
    ST_REFRESH
  } state_t;

  state_t              state_reg, state_next;
  logic                row_open_reg;
  logic [ROW_W-1:0]    open_row_reg;
  logic [TMR_W-1:0]    ref_tmr_reg;
  logic                ref_pending_reg;
  logic [ACT_CW-1:0]   act_cnt_reg;
  logic [REF_CW-1:0]   ref_cnt_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready;
  logic                accept;
  logic                is_hit, is_miss, is_conflict;
  logic                tmr_expire;
  logic                enter_refresh;
  logic                act_done;
  logic [ROW_W-1:0]    req_row;
  logic [ROW_W-1:0]    cap_row;

  always_comb begin
    req_row       = bus.req_addr[ADDR_W-1:COL_W];
    cap_row       = addr_reg[ADDR_W-1:COL_W];
    tmr_expire    = (ref_tmr_reg == TMR_LAST);
    ready         = (state_reg == ST_IDLE) && !ref_pending_reg;
    accept        = bus.req_valid && ready;
    is_hit        = accept && row_open_reg && (open_row_reg == req_row);
    is_miss       = accept && !row_open_reg;
    is_conflict   = accept && row_open_reg && (open_row_reg != req_row);
    enter_refresh = (state_reg == ST_IDLE) && ref_pending_reg;
    act_done      = (state_reg == ST_ACTIVATE) && (act_cnt_reg == '0);
  end

  assign bus.req_ready    = ready;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_rdata    = rsp_rdata_reg;
  assign bus.refresh_busy = (state_reg == ST_REFRESH);

  // Refresh has priority; requests are only ever accepted from IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ref_pending_reg)  state_next = ST_REFRESH;
        else if (is_hit)      state_next = ST_ACCESS;
        else if (is_miss)     state_next = ST_ACTIVATE;
        else if (is_conflict) state_next = ST_PRECHARGE;
      end
      ST_PRECHARGE: state_next = ST_ACTIVATE;
      ST_ACTIVATE:  if (act_cnt_reg == '0) state_next = ST_ACCESS;
      ST_ACCESS:    state_next = ST_IDLE;
      ST_REFRESH:   if (ref_cnt_reg == '0) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      row_open_reg    <= 1'b0;
      open_row_reg    <= '0;
      ref_tmr_reg     <= '0;
      ref_pending_reg <= 1'b0;
      act_cnt_reg     <= '0;
      ref_cnt_reg     <= '0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      ref_tmr_reg <= tmr_expire ? '0 : ref_tmr_reg + 1'b1;

      // A new expiry wins over the clear; a second expiry while pending is simply absorbed.
      if (tmr_expire)         ref_pending_reg <= 1'b1;
      else if (enter_refresh) ref_pending_reg <= 1'b0;

      if (accept) begin
        we_reg    <= bus.req_we;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
      end

      if (state_next == ST_ACTIVATE && state_reg != ST_ACTIVATE)
        act_cnt_reg <= ACT_LOAD;
      else if (state_reg == ST_ACTIVATE && act_cnt_reg != '0)
        act_cnt_reg <= act_cnt_reg - 1'b1;

      if (enter_refresh)
        ref_cnt_reg <= REF_LOAD;
      else if (state_reg == ST_REFRESH && ref_cnt_reg != '0)
        ref_cnt_reg <= ref_cnt_reg - 1'b1;

      if (enter_refresh) begin
        row_open_reg <= 1'b0;
        open_row_reg <= '0;
      end else if (state_reg == ST_PRECHARGE) begin
        row_open_reg <= 1'b0;
      end else if (act_done) begin
        row_open_reg <= 1'b1;
        open_row_reg <= cap_row;
      end

      rsp_valid_reg <= (state_reg == ST_ACCESS) && !we_reg;
      if (state_reg == ST_ACCESS && !we_reg)
        rsp_rdata_reg <= mem[addr_reg];
    end
  end

  // Array has no reset; state is forced to IDLE by reset, which drops any in-flight write.
  always_ff @(posedge clk) begin
    if (state_reg == ST_ACCESS && we_reg)
      mem[addr_reg] <= wdata_reg;
  end

`ifdef DRAM_BANK_STATS_EN
  logic [2:0]  stat_inc;
  logic [15:0] stat_reg [3];

  assign stat_inc = {is_conflict, is_miss, is_hit};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stat_reg[gi] <= '0;
      else if (stat_inc[gi] && stat_reg[gi] != 16'hFFFF)
        stat_reg[gi] <= stat_reg[gi] + 16'd1;
    end
  end

  assign stat_hits      = stat_reg[0];
  assign stat_misses    = stat_reg[1];
  assign stat_conflicts = stat_reg[2];
`endif

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Randomized bench for dram_bank_ctrl against a cycle-numbered reference model
// (open row, refresh schedule, memory image); also checks stats when DRAM_BANK_STATS_EN is set.
module tb_dram_bank_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int COL_W  = 2;
  localparam int ROW_W  = ADDR_W - COL_W;
  localparam int T_ACT  = 2;
  localparam int T_REF  = 4;
  localparam int RP     = 64;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef DRAM_BANK_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_conflicts;
`endif

  dram_bank_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .COL_W(COL_W),
    .T_ACT(T_ACT), .T_REF(T_REF), .REFRESH_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef DRAM_BANK_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses),
    .stat_conflicts(stat_conflicts)
`endif
  );

  // Cycle index since reset release: 0 in the first cycle after release.
  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_vec  = 0;
  int n_err  = 0;
  int n_xact = 0;

  // Reference model state, all in absolute cycle numbers.
  int f_cyc;     // first cycle the controller is idle again
  int r_cyc;     // first cycle a refresh request is visible
  int open_row;  // -1 when no row is open
  int win_lo, win_hi;
  int rsp_cyc;
  bit pw_v;
  int pw_cyc;
  logic [ADDR_W-1:0] pw_addr;
  logic [DATA_W-1:0] pw_data;
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DATA_W-1:0] rsp_exp, last_rdata;
  int m_hits, m_misses, m_conf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    f_cyc = 0; r_cyc = RP; open_row = -1;
    win_lo = -1; win_hi = -2; rsp_cyc = -1;
    pw_v = 0; last_rdata = '0;
    m_hits = 0; m_misses = 0; m_conf = 0;
  endtask

  // Refresh starts on the first idle cycle at or after the request becomes visible.
  task automatic settle(input int t);
    int i;
    i = (f_cyc > r_cyc) ? f_cyc : r_cyc;
    while (i <= t) begin
      win_lo   = i + 1;
      win_hi   = i + T_REF;
      f_cyc    = i + 1 + T_REF;
      open_row = -1;
      r_cyc    = (i / RP + 1) * RP;
      i = (f_cyc > r_cyc) ? f_cyc : r_cyc;
    end
  endtask

  task automatic step();
    settle(cyc);
    if (pw_v && cyc > pw_cyc) begin
      mem_m[pw_addr] = pw_data;
      pw_v = 0;
    end
    check_val("req_ready", 32'(bus.req_ready), 32'(cyc >= f_cyc));
    check_val("refresh_busy", 32'(bus.refresh_busy), 32'(cyc >= win_lo && cyc <= win_hi));
    check_val("rsp_valid", 32'(bus.rsp_valid), 32'(cyc == rsp_cyc));
    if (cyc == rsp_cyc) last_rdata = rsp_exp;
    check_val("rsp_rdata", 32'(bus.rsp_rdata), 32'(last_rdata));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    step();
  endtask

  task automatic model_accept(input int c, input bit we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, output string cls);
    int row, lat;
    row = int'(addr >> COL_W);
    if (open_row == row) begin
      lat = 2; m_hits++; cls = "hit";
    end else if (open_row < 0) begin
      lat = 2 + T_ACT; m_misses++; cls = "miss";
    end else begin
      lat = 3 + T_ACT; m_conf++; cls = "conflict";
    end
    open_row = row;
    f_cyc    = c + lat;
    if (we) begin
      pw_v = 1; pw_cyc = c + lat - 1; pw_addr = addr; pw_data = wd;
    end else begin
      rsp_cyc = c + lat;
      rsp_exp = mem_m[addr];
    end
  endtask

  // Presents one request, returns one cycle after acceptance.
  task automatic xact(input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, output int acc_cyc);
    bit    done;
    string cls;
    done    = 0;
    acc_cyc = -1;
    cls     = "";
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    for (int k = 0; k < 100 && !done; k++) begin
      if (bus.req_ready === 1'b1) begin
        done    = 1;
        acc_cyc = cyc;
        model_accept(cyc, we, addr, wd, cls);
      end
      tick();
    end
    bus.req_valid = 1'b0;
    n_xact++;
    if (!done) check_val("accept_timeout", 32'd0, 32'd1);
    else $display("xact %0d: %s addr=0x%02h wdata=0x%02h %s accepted at cycle %0d",
                  n_xact, we ? "WR" : "RD", addr, wd, cls, acc_cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check_val({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_val({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check_val({tag, "_refresh_busy"}, 32'(bus.refresh_busy), 32'd0);
`ifdef DRAM_BANK_STATS_EN
    check_val({tag, "_stat_hits"}, 32'(stat_hits), 32'd0);
    check_val({tag, "_stat_misses"}, 32'(stat_misses), 32'd0);
    check_val({tag, "_stat_conflicts"}, 32'(stat_conflicts), 32'd0);
`endif
  endtask

  task automatic rand_phase(input int n);
    int acc, gap;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    row = '0;
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 3) == 0) row = ROW_W'($urandom_range(0, 2 ** ROW_W - 1));
      addr = {row, COL_W'($urandom_range(0, 2 ** COL_W - 1))};
      xact(1'($urandom_range(0, 1)), addr, DATA_W'($urandom), acc);
      gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(10, 70)) : int'($urandom_range(0, 2));
      repeat (gap) tick();
    end
  endtask

  initial begin
    int acc, s;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    model_reset();
    step();

    // Miss write then hit read, then a row conflict.
    xact(1'b1, 6'h04, 8'hA5, acc);
    xact(1'b0, 6'h04, 8'h00, acc);
    xact(1'b1, 6'h28, 8'h5A, acc);
    xact(1'b0, 6'h28, 8'h00, acc);
    repeat (3) tick();

    for (int a = 0; a < DEPTH; a++) begin
      if (a != 'h04 && a != 'h28) xact(1'b1, ADDR_W'(a), DATA_W'($urandom), acc);
    end

    // Request presented in the very cycle a refresh request is pending.
    repeat (8) tick();
    for (int k = 0; k < RP + 2 && (cyc % RP) != RP - 1; k++) tick();
    tick();
    s = cyc;
    xact(1'b0, 6'h04, 8'h00, acc);
    check_val("refresh_wins_delay", 32'(acc - s), 32'(T_REF + 1));
    repeat (4) tick();

    rand_phase(300);

    // Reset while the second write to 0x10 sits in ACTIVATE.
    repeat (6) tick();
    xact(1'b1, 6'h10, 8'hC3, acc);
    xact(1'b0, 6'h00, 8'h00, acc);
    xact(1'b1, 6'h10, 8'h33, acc);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();

    // miss, hit, conflict, hit
    xact(1'b0, 6'h10, 8'h00, acc);
    xact(1'b0, 6'h11, 8'h00, acc);
    xact(1'b0, 6'h20, 8'h00, acc);
    xact(1'b0, 6'h21, 8'h00, acc);
    repeat (3) tick();
`ifdef DRAM_BANK_STATS_EN
    check_val("stat_hits_seq", 32'(stat_hits), 32'd2);
    check_val("stat_misses_seq", 32'(stat_misses), 32'd1);
    check_val("stat_conflicts_seq", 32'(stat_conflicts), 32'd1);
`endif

    rand_phase(60);
    repeat (10) tick();
`ifdef DRAM_BANK_STATS_EN
    check_val("stat_hits_end", 32'(stat_hits), 32'(m_hits));
    check_val("stat_misses_end", 32'(stat_misses), 32'(m_misses));
    check_val("stat_conflicts_end", 32'(stat_conflicts), 32'(m_conf));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
